// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the core's memory stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, programmable wait states,
// byte-lane stores, aligned/extended loads, owns a word-organised RAM array.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int unsigned DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              accept, commit;

  logic              we_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [31:0]       mem [DEPTH];

  logic [31:0]       rd_word, ld_data, st_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [3:0]        st_be;
  logic              acc_err;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        state_nx = BUSY;
        cnt_nx   = 4'(WAIT_STATES);
        accept   = 1'b1;
      end
      BUSY: if (cnt != '0) begin
        cnt_nx = cnt - 4'd1;
      end else begin
        state_nx = RESP;
        commit   = 1'b1;
      end
      RESP: if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Access decode works on the captured request only, so req_* may change freely after acceptance.
  always_comb begin
    rd_word = mem[addr_q[ADDR_W-1:2]];
    ld_byte = 8'(rd_word >> {addr_q[1:0], 3'b000});
    ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    case (size_q)
      3'b000, 3'b100: acc_err = we_q & size_q[2];
      3'b001, 3'b101: acc_err = (we_q & size_q[2]) | addr_q[0];
      3'b010:         acc_err = |addr_q[1:0];
      default:        acc_err = 1'b1;
    endcase

    case (size_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      3'b010:  ld_data = rd_word;
      default: ld_data = '0;
    endcase

    case (size_q[1:0])
      2'b00: begin
        st_word = {4{wdata_q[7:0]}};
        st_be   = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        st_word = {2{wdata_q[15:0]}};
        st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_word = wdata_q;
        st_be   = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (commit) begin
        rsp_err_q   <= acc_err;
        rsp_rdata_q <= (acc_err | we_q) ? '0 : ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // commit is only reachable from BUSY, so an asserted reset also blocks the write.
  always_ff @(posedge clk) begin
    if (commit && we_q && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (st_be[i]) mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= st_word[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
